// File: rtl/salto_predictor_pkg.sv
// -----------------------------------------------------------------------------
// salto_predictor_pkg
// Shared pipeline constants for the branch predictor: 2-bit saturating counter
// encodings, the counter value used when a new entry is allocated, the counter
// value an entry holds out of reset, and the saturating counter step.
// -----------------------------------------------------------------------------
package salto_predictor_pkg;

  // 2-bit counter encodings; bit 1 is the taken/not-taken prediction.
  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  // A freshly allocated entry starts weakly taken: it predicts taken next
  // time, but a single not-taken outcome flips it back.
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  // Reset value: weakly not taken.
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  // Saturating counter step towards the observed outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                          input logic       taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage : salto_predictor_pkg

// File: rtl/salto_target_adder.sv
// -----------------------------------------------------------------------------
// salto_target_adder
// Purely combinational address arithmetic for a resolving branch.
//   pc     : PC of the resolving branch
//   offset : sign-extended branch offset, in units of (1 << SHIFT) bytes
//   tgt    : pc + (offset << SHIFT), modulo 2^WIDTH
//   fall   : pc + (1 << SHIFT),      modulo 2^WIDTH
// Carries out of the top bit are simply dropped, so targets wrap around.
// -----------------------------------------------------------------------------
module salto_target_adder #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 2
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] fall
);

  localparam logic [WIDTH-1:0] STEP = {{(WIDTH-1){1'b0}}, 1'b1} << SHIFT;

  // The shift discards the offset's top SHIFT bits; that cannot change the
  // sum modulo 2^WIDTH, so the sign of a negative offset is preserved.
  assign tgt  = pc + (offset << SHIFT);
  assign fall = pc + STEP;

endmodule : salto_target_adder

// File: rtl/salto_predictor.sv
// -----------------------------------------------------------------------------
// salto_predictor
// Direct-mapped branch target buffer with 2-bit saturating counters.
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   fetch_pc                    : PC being fetched this cycle
//   pred_taken, pred_target     : combinational prediction for fetch_pc
//   res_valid                   : a branch resolves this cycle
//   res_pc, res_offset          : resolving branch PC and sign-extended offset
//   res_taken                   : actual outcome
//   res_pred_taken/target       : prediction that was made at fetch time
//   redirect, redirect_pc       : registered one-cycle mispredict pulse and the
//                                 correct next PC (redirect_pc holds otherwise)
//
// Lookups read the table as it stands at the start of the cycle; an update in
// the same cycle becomes visible from the next cycle.
// -----------------------------------------------------------------------------
module salto_predictor
  import salto_predictor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_pc,
  input  logic [WIDTH-1:0] res_offset,
  input  logic             res_taken,
  input  logic             res_pred_taken,
  input  logic [WIDTH-1:0] res_pred_target,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = WIDTH - SHIFT - IDX_W;
  localparam logic [WIDTH-1:0] STEP = {{(WIDTH-1){1'b0}}, 1'b1} << SHIFT;

  // ---------------------------------------------------------------------------
  // Table state
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [1:0]       ctr_q    [DEPTH];
  logic [1:0]       ctr_d    [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [TAG_W-1:0] tag_d    [DEPTH];
  logic [WIDTH-1:0] target_q [DEPTH];
  logic [WIDTH-1:0] target_d [DEPTH];

  // Redirect register and the update-enable flag
  logic             redirect_q, redirect_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic             en_q, en_d;

  // ---------------------------------------------------------------------------
  // Fetch-side lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;

  assign fetch_idx = fetch_pc[SHIFT +: IDX_W];
  assign fetch_tag = fetch_pc[WIDTH-1 -: TAG_W];
  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  assign pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
  assign pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + STEP;

  // ---------------------------------------------------------------------------
  // Resolution side
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] res_tgt;
  logic [WIDTH-1:0] res_fall;
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  logic             res_hit;
  logic             res_act;
  logic             mispredict;

  salto_target_adder #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT)
  ) u_target_adder (
    .pc     (res_pc),
    .offset (res_offset),
    .tgt    (res_tgt),
    .fall   (res_fall)
  );

  assign res_idx = res_pc[SHIFT +: IDX_W];
  assign res_tag = res_pc[WIDTH-1 -: TAG_W];
  assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

  // en_q stays low through the first edge after reset is released, so a
  // resolution presented in that cycle is dropped.
  assign res_act = res_valid && en_q;

  assign mispredict = res_act &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && (res_pred_target != res_tgt)));

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    valid_d       = valid_q;
    ctr_d         = ctr_q;
    tag_d         = tag_q;
    target_d      = target_q;
    en_d          = 1'b1;
    redirect_d    = mispredict;
    redirect_pc_d = redirect_pc_q;

    if (mispredict) begin
      redirect_pc_d = res_taken ? res_tgt : res_fall;
    end

    if (res_act) begin
      if (res_hit) begin
        ctr_d[res_idx] = ctr_next(ctr_q[res_idx], res_taken);
        if (res_taken) begin
          target_d[res_idx] = res_tgt;
        end
      end else if (res_taken) begin
        // Miss on a taken branch: replace whatever lives at this index.
        valid_d[res_idx]  = 1'b1;
        tag_d[res_idx]    = res_tag;
        target_d[res_idx] = res_tgt;
        ctr_d[res_idx]    = CTR_ALLOC;
      end
      // Miss on a not-taken branch leaves the table alone.
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= CTR_RESET;
      end
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      en_q          <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      en_q          <= en_d;
    end
  end

  // NOTE: tags and targets are storage behind a valid bit, so they carry no
  // reset; a cleared valid bit already makes their contents irrelevant.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule : salto_predictor

// File: tb/tb_salto_predictor.sv
// -----------------------------------------------------------------------------
// tb_salto_predictor
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared against a behavioural table model kept in plain arrays.
// -----------------------------------------------------------------------------
module tb_salto_predictor;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  fetch_pc = '0;
  logic          pred_taken;
  logic [W-1:0]  pred_target;
  logic          res_valid = 1'b0;
  logic [W-1:0]  res_pc = '0;
  logic [W-1:0]  res_offset = '0;
  logic          res_taken = 1'b0;
  logic          res_pred_taken = 1'b0;
  logic [W-1:0]  res_pred_target = '0;
  logic          redirect;
  logic [W-1:0]  redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  salto_predictor dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_offset      (res_offset),
    .res_taken       (res_taken),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: 16 entries, 4-byte granularity, tag = pc >> 6.
  // ---------------------------------------------------------------------------
  bit           m_valid [16];
  int unsigned  m_tag   [16];
  logic [W-1:0] m_tgt   [16];
  int           m_ctr   [16];
  logic [W-1:0] m_rpc;
  bit           m_ignore;

  function automatic int m_idx(input logic [W-1:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_rpc = '0;
  endfunction

  function automatic void m_lookup(input logic [W-1:0] pc, output bit t,
                                   output logic [W-1:0] target);
    int  i   = m_idx(pc);
    bit  hit = m_valid[i] && (m_tag[i] == int'(pc >> 6));
    t      = hit && (m_ctr[i] >= 2);
    target = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  // One cycle of stimulus: lookup checked before the edge, redirect after.
  task automatic do_cycle(input logic [W-1:0] f_pc, input logic rv,
                          input logic [W-1:0] rpc, input logic [W-1:0] roff,
                          input logic rt, input logic rpt,
                          input logic [W-1:0] rptgt);
    bit           e_t;
    logic [W-1:0] e_tg;
    logic [W-1:0] tgt;
    logic [W-1:0] fall;
    bit           mis;
    bit           e_redir;
    int           i;
    bit           hit;

    fetch_pc = f_pc;  res_valid = rv;  res_pc = rpc;  res_offset = roff;
    res_taken = rt;   res_pred_taken = rpt;  res_pred_target = rptgt;
    #1;
    m_lookup(f_pc, e_t, e_tg);
    check("pred_taken", W'(pred_taken), W'(e_t));
    check("pred_target", pred_target, e_tg);

    tgt  = rpc + (roff << 2);
    fall = rpc + 32'd4;
    i    = m_idx(rpc);
    hit  = m_valid[i] && (m_tag[i] == int'(rpc >> 6));
    e_redir = 0;
    if (m_ignore) begin
      m_ignore = 0;
    end else if (rv) begin
      mis = (rt != rpt) || (rt && (rptgt != tgt));
      e_redir = mis;
      if (mis) m_rpc = rt ? tgt : fall;
      if (hit) begin
        m_ctr[i] = rt ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                      : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (rt) m_tgt[i] = tgt;
      end else if (rt) begin
        m_valid[i] = 1;
        m_tag[i]   = int'(rpc >> 6);
        m_tgt[i]   = tgt;
        m_ctr[i]   = 2;
      end
    end

    @(posedge clk);
    #1;
    check("redirect", W'(redirect), W'(e_redir));
    check("redirect_pc", redirect_pc, m_rpc);
  endtask

  // Combinational lookup against fixed values, without advancing the clock.
  task automatic peek(input string tag, input logic [W-1:0] pc,
                      input logic exp_t, input logic [W-1:0] exp_tg);
    fetch_pc  = pc;
    res_valid = 1'b0;
    #1;
    check({tag, "_taken"}, W'(pred_taken), W'(exp_t));
    check({tag, "_target"}, pred_target, exp_tg);
  endtask

  task automatic assert_reset();
    rst_n     = 1'b0;
    res_valid = 1'b0;
    #1;
    check("rst_redirect", W'(redirect), '0);
    check("rst_redirect_pc", redirect_pc, '0);
    m_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    m_ignore = 1;
  endtask

  initial begin
    bit           pt;
    logic [W-1:0] ptg;
    logic [W-1:0] rpc;
    logic [W-1:0] roff;
    logic [W-1:0] fpc;

    #1;
    assert_reset();
    peek("rst_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);
    release_reset();

    // Resolution in the release cycle must be dropped.
    do_cycle(32'h0040_0010, 1, 32'h0040_0010, 32'h4, 1, 0, '0);
    peek("ignored_res", 32'h0040_0010, 1'b0, 32'h0040_0014);

    // Taken miss allocates; mispredict redirects to the target.
    do_cycle(32'h0040_0010, 1, 32'h0040_0010, 32'h4, 1, 0, '0);
    check("alloc_redirect_pc", redirect_pc, 32'h0040_0020);
    peek("alloc_lookup", 32'h0040_0010, 1'b1, 32'h0040_0020);

    // Two not-taken outcomes: 10 -> 01 -> 00.
    do_cycle(32'h0040_0010, 1, 32'h0040_0010, 32'h4, 0, 1, 32'h0040_0020);
    check("nt1_redirect_pc", redirect_pc, 32'h0040_0014);
    peek("nt1_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);
    do_cycle(32'h0040_0010, 1, 32'h0040_0010, 32'h4, 0, 0, 32'h0040_0014);
    check("nt2_redirect", W'(redirect), '0);
    // From 00 a single taken only reaches 01: still predicts not taken.
    do_cycle(32'h0040_0010, 1, 32'h0040_0010, 32'h4, 1, 0, '0);
    peek("sat_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);

    // Wrap-around target, then a negative offset on a hit (01 -> 10).
    do_cycle(32'h0040_0010, 1, 32'hFFFF_FFFC, 32'h2, 1, 0, '0);
    check("wrap_redirect_pc", redirect_pc, 32'h0000_0004);
    do_cycle(32'h0040_0010, 1, 32'h0040_0010, 32'hFFFF_FFFF, 1, 0, '0);
    check("neg_redirect_pc", redirect_pc, 32'h0040_000C);
    peek("neg_lookup", 32'h0040_0010, 1'b1, 32'h0040_000C);

    // Aliasing: same index, different tag replaces the entry.
    do_cycle(32'h0040_0010, 1, 32'h0040_0050, 32'h4, 1, 0, '0);
    peek("alias_old", 32'h0040_0010, 1'b0, 32'h0040_0014);
    peek("alias_new", 32'h0040_0050, 1'b1, 32'h0040_0060);

    // Same-cycle lookup and update: old prediction now, new one next cycle.
    do_cycle(32'h0040_0050, 1, 32'h0040_0050, 32'h4, 0, 1, 32'h0040_0060);
    peek("same_idx_after", 32'h0040_0050, 1'b0, 32'h0040_0054);

    // Reset while a redirect is being presented.
    do_cycle(32'h0040_0050, 1, 32'h0040_0090, 32'h8, 1, 0, '0);
    check("pre_rst_redirect", W'(redirect), 32'h1);
    assert_reset();
    peek("post_rst_a", 32'h0040_0090, 1'b0, 32'h0040_0094);
    peek("post_rst_b", 32'h0040_0050, 1'b0, 32'h0040_0054);
    release_reset();

    // Randomized traffic over a small PC pool so entries hit and alias.
    for (int n = 0; n < 400; n++) begin
      rpc  = 32'h0040_0000 | ($urandom_range(0, 2) << 6)
                           | ($urandom_range(0, 15) << 2);
      fpc  = 32'h0040_0000 | ($urandom_range(0, 2) << 6)
                           | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 19) == 0) rpc = $urandom() & 32'hFFFF_FFFC;
      roff = W'($signed($urandom_range(0, 64)) - 32);
      if ($urandom_range(0, 9) == 0) roff = $urandom();
      m_lookup(rpc, pt, ptg);
      if ($urandom_range(0, 9) < 3) begin
        pt  = 1'($urandom());
        ptg = ($urandom_range(0, 1) == 0) ? $urandom() : rpc + (roff << 2);
      end
      do_cycle(fpc, 1'($urandom_range(0, 3) != 0), rpc, roff,
               1'($urandom()), pt, ptg);
      if (n == 200) begin
        assert_reset();
        release_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_salto_predictor
